nor_gate_array_filt: RTL and testbench

- Parametrised successor to the single 2-input NOR cell: CHANNELS independent 2-input gates, each NOR (or OR, by mode).
- Each input bit is synchronised to clk. Each gate output passes through a programmable glitch/debounce filter before being registered.
- Per-channel sticky change flags with acknowledge handshake plus a combined irq, so a controller can react to filtered edges instead of polling.
- Sits between raw board-level logic inputs and the synchronous control fabric.

---
 rtl/nor_gate_array_filt_pkg.sv | 10 +
 rtl/nor_gate_array_filt_chan_filter.sv | 77 +++++++
 rtl/nor_gate_array_filt.sv | 50 +++++
 tb/tb_nor_gate_array_filt.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_gate_array_filt_pkg.sv
// Shared constants for the NOR/OR gate array with per-channel glitch filtering.
package nor_gate_array_pkg;

  localparam int   DEF_CHANNELS = 4;
  localparam int   DEF_FILT_W   = 4;

  localparam logic MODE_NOR = 1'b0;
  localparam logic MODE_OR  = 1'b1;

endpackage

// File: rtl/nor_gate_array_filt_chan_filter.sv
// One channel: input synchronisers, NOR/OR gate, mismatch counter filter,
// registered output and sticky change flag.
module nor_chan_filter
  import nor_gate_array_pkg::*;
#(
  parameter int FILT_W = DEF_FILT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              chg_ack,
  output logic              out,
  output logic              chg_flag,
  output logic              chg_flag_nxt
);

  logic              a_m_q, a_m_d, s_a_q, s_a_d;
  logic              b_m_q, b_m_d, s_b_q, s_b_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              chg_flag_q, chg_flag_d;
  logic              raw;
  logic              toggle;

  always_comb begin
    a_m_d  = a;
    s_a_d  = a_m_q;
    b_m_d  = b;
    s_b_d  = b_m_q;
    raw    = (mode == MODE_OR) ? (s_a_q | s_b_q) : ~(s_a_q | s_b_q);
    cnt_d  = cnt_q;
    out_d  = out_q;
    toggle = 1'b0;

    // cnt is bounded by filt_len, so it can never wrap.
    if (raw == out_q) begin
      cnt_d = '0;
    end else if (cnt_q < filt_len) begin
      cnt_d = cnt_q + FILT_W'(1);
    end else begin
      out_d  = raw;
      cnt_d  = '0;
      toggle = 1'b1;
    end

    // A toggle on the ack edge wins over the clear.
    chg_flag_d = toggle | (chg_flag_q & ~chg_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_m_q      <= 1'b0;
      s_a_q      <= 1'b0;
      b_m_q      <= 1'b0;
      s_b_q      <= 1'b0;
      cnt_q      <= '0;
      out_q      <= 1'b1;
      chg_flag_q <= 1'b0;
    end else begin
      a_m_q      <= a_m_d;
      s_a_q      <= s_a_d;
      b_m_q      <= b_m_d;
      s_b_q      <= s_b_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      chg_flag_q <= chg_flag_d;
    end
  end

  assign out          = out_q;
  assign chg_flag     = chg_flag_q;
  assign chg_flag_nxt = chg_flag_d;

endmodule

// File: rtl/nor_gate_array_filt.sv
// Array of independently filtered NOR/OR gates with a combined change interrupt.
module nor_gate_array_filt
  import nor_gate_array_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FILT_W   = DEF_FILT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  input  logic                mode,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [CHANNELS-1:0] chg_ack,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] chg_flag,
  output logic                irq
);

  logic [CHANNELS-1:0] chg_flag_nxt;
  logic                irq_q, irq_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    nor_chan_filter #(
      .FILT_W(FILT_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a[i]),
      .b            (b[i]),
      .mode         (mode),
      .filt_len     (filt_len),
      .chg_ack      (chg_ack[i]),
      .out          (out[i]),
      .chg_flag     (chg_flag[i]),
      .chg_flag_nxt (chg_flag_nxt[i])
    );
  end

  // Built from next-state flags so irq moves on the same edge as chg_flag.
  always_comb irq_d = |chg_flag_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_nor_gate_array_filt.sv
// Bench for nor_gate_array_filt: fixed vector table, directed corner sequences,
// then random stimulus against a cycle-level reference model.
module tb_nor_gate_array_filt;

  localparam int CH = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] a, b, chg_ack;
  logic          mode;
  logic [FW-1:0] filt_len;
  logic [CH-1:0] out, chg_flag;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  nor_gate_array_filt #(.CHANNELS(CH), .FILT_W(FW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .filt_len (filt_len),
    .chg_ack  (chg_ack),
    .out      (out),
    .chg_flag (chg_flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: inputs become visible two edges after they are sampled;
  // an output follows its gate result once the mismatch has persisted for
  // filt_len+1 consecutive edges.
  logic [CH-1:0] seen_a [2];
  logic [CH-1:0] seen_b [2];
  logic [CH-1:0] m_out, m_flag;
  logic          m_irq;
  int            m_run [CH];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      seen_a[k] = '0;
      seen_b[k] = '0;
    end
    m_out  = '1;
    m_flag = '0;
    m_irq  = 1'b0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
  endfunction

  function automatic void model_step();
    logic [CH-1:0] nflag;
    logic          r;
    nflag = m_flag & ~chg_ack;
    for (int i = 0; i < CH; i++) begin
      r = mode ? (seen_a[1][i] | seen_b[1][i]) : !(seen_a[1][i] | seen_b[1][i]);
      if (r == m_out[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] >= int'(filt_len)) begin
        m_out[i] = r;
        m_run[i] = 0;
        nflag[i] = 1'b1;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
    end
    m_flag    = nflag;
    m_irq     = |nflag;
    seen_a[1] = seen_a[0];
    seen_b[1] = seen_b[0];
    seen_a[0] = a;
    seen_b[0] = b;
  endfunction

  task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Advance one edge, then compare the DUT with the model.
  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    n_vec++;
    if (out !== m_out || chg_flag !== m_flag || irq !== m_irq) begin
      n_err++;
      $display("FAIL %s @%0t: out=%b flag=%b irq=%b, expected out=%b flag=%b irq=%b",
               name, $time, out, chg_flag, irq, m_out, m_flag, m_irq);
    end
  endtask

  typedef struct {
    logic [CH-1:0] a, b, ack;
    logic [CH-1:0] e_out, e_flag;
    logic          e_irq;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int e;
    //            a     b     ack   out   flag  irq
    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'hE, 4'h1, 1'b1};
    tbl[3]  = '{4'h1, 4'h0, 4'h1, 4'hE, 4'h0, 1'b0};
    tbl[4]  = '{4'h0, 4'h2, 4'h0, 4'hE, 4'h0, 1'b0};
    tbl[5]  = '{4'h0, 4'h2, 4'h0, 4'hE, 4'h0, 1'b0};
    tbl[6]  = '{4'h0, 4'h2, 4'h0, 4'hD, 4'h3, 1'b1};
    tbl[7]  = '{4'h0, 4'h2, 4'h3, 4'hD, 4'h0, 1'b0};
    tbl[8]  = '{4'h0, 4'h0, 4'h1, 4'hD, 4'h0, 1'b0};
    tbl[9]  = '{4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 1'b0};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h2, 1'b1};
    tbl[11] = '{4'h0, 4'h0, 4'h2, 4'hF, 4'h0, 1'b0};

    rst_n = 1'b0; a = '0; b = '0; chg_ack = '0; mode = 1'b0; filt_len = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", out, 4'hF);
    chk("reset_flag", chg_flag, 4'h0);
    chk("reset_irq", {3'b0, irq}, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick("idle");
    chk("idle_out", out, 4'hF);

    // Pass-through (filt_len=0) latency, ack and ack-while-clear.
    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a; b = tbl[i].b; chg_ack = tbl[i].ack;
      tick("table_model");
      chk($sformatf("table%0d_out", i), out, tbl[i].e_out);
      chk($sformatf("table%0d_flag", i), chg_flag, tbl[i].e_flag);
      chk($sformatf("table%0d_irq", i), {3'b0, irq}, {3'b0, tbl[i].e_irq});
    end
    chg_ack = '0;

    // Glitch of exactly filt_len sampled cycles is rejected.
    filt_len = 4'd3;
    b = 4'h2;
    repeat (3) tick("glitch_hi");
    b = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick("glitch_lo");
      chk("glitch_out1", {3'b0, out[1]}, 4'h1);
    end
    // Held input is accepted on edge 3+filt_len.
    b = 4'h2;
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick("accept");
      if (out[1] == 1'b0) e = i;
    end
    chk("accept_edge", 4'(e), 4'd6);

    // Ack clears; toggle on the ack edge keeps the flag set.
    filt_len = 4'd0;
    chg_ack = 4'hF; tick("ack_all"); chg_ack = '0;
    a = 4'h4;
    repeat (3) tick("flag2_set");
    chk("flag2_set", chg_flag, 4'h4);
    chg_ack = 4'h4; tick("ack2");
    chg_ack = '0;
    chk("ack2_flag", chg_flag, 4'h0);
    chk("ack2_irq", {3'b0, irq}, 4'h0);
    a = 4'h0;
    tick("sw_0"); tick("sw_1");
    chg_ack = 4'h4; tick("set_wins");
    chg_ack = '0;
    chk("set_wins_flag", {3'b0, chg_flag[2]}, 4'h1);
    chk("set_wins_out", {3'b0, out[2]}, 4'h1);

    // Mode change flips all channels together.
    b = '0;
    repeat (4) tick("settle");
    chg_ack = 4'hF; tick("ack_all"); chg_ack = '0;
    filt_len = 4'd1;
    mode = 1'b1;
    tick("mode_1");
    chk("mode_e1_out", out, 4'hF);
    tick("mode_2");
    chk("mode_e2_out", out, 4'h0);
    chk("mode_e2_flag", chg_flag, 4'hF);
    chk("mode_e2_irq", {3'b0, irq}, 4'h1);
    chg_ack = 4'hF; tick("ack_all"); chg_ack = '0;

    // Shrinking filt_len below the running count releases on the next edge.
    filt_len = 4'd5;
    a = 4'h8;
    repeat (5) tick("shrink_cnt");
    chk("shrink_hold", {3'b0, out[3]}, 4'h0);
    filt_len = 4'd1;
    tick("shrink_rel");
    chk("shrink_out3", {3'b0, out[3]}, 4'h1);

    // Asynchronous reset mid-count, then a full re-filter.
    filt_len = 4'd8;
    a = 4'h9;
    repeat (5) tick("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 4'hF);
    chk("async_rst_flag", chg_flag, 4'h0);
    chk("async_rst_irq", {3'b0, irq}, 4'h0);
    model_reset();
    mode = 1'b0;
    filt_len = 4'd2;
    @(negedge clk) rst_n = 1'b1;
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick("refilter");
      if (out[0] == 1'b0) e = i;
    end
    chk("refilter_edge", 4'(e), 4'd5);
    chk("refilter_out", out, 4'h6);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) a = CH'($urandom);
      if ($urandom_range(0, 3) == 0) b = CH'($urandom);
      if ($urandom_range(0, 31) == 0) filt_len = FW'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      chg_ack = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
